keccak_load_stage: RTL and testbench
====================================

Name: keccak_load_stage

Overview:
- Parametrised successor to the sponge input/load stage.
- Accepts a header word, then message words over valid/ready.
- Applies FIPS-202 padding with a mode-dependent domain suffix and assembles rate-sized blocks for the permutation stage.
- Supports all six SHA3/SHAKE modes and a configurable word width; emits blocks via a blk_valid/blk_ready handshake.

Parameters:
- W, 64, data word width in bits; legal values 32 or 64.
- RATE_MAX, 1344, widest rate (SHAKE128) in bits; blk_data width.
- SIZE_W, 32, width of the input-size field and counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  in_data valid
- in_ready  out  1  stage accepts in_data this cycle
- in_data  in  W  header or message word; first message byte in [W-1:W-8]
- blk_valid  out  1  blk_data holds a complete padded block
- blk_ready  in  1  downstream consumes block
- blk_data  out  RATE_MAX  block, little-endian per word; word i at [i*W+W-1:i*W]; bits above the mode rate are 0
- blk_last  out  1  block is the final (padded) block of the message
- out_mode  out  3  latched mode
- out_size  out  SIZE_W  latched output length field
- err  out  1  invalid-mode pulse (see Optional Feature)

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0, FSM in IDLE, blk_data cleared, counters cleared.
- Header layout for W=64: mode=[63:61], out_size={4'b0,[59:32]}, in_size_bits=[31:0].
- Header layout for W=32: two header beats, high beat first, with the same field positions.
- Modes, with rate words for W=64 (double for W=32) and suffix:
  - 0 SHAKE128: 21 words, 0x1F
  - 1 SHAKE256: 17 words, 0x1F
  - 2 SHA3-224: 18 words, 0x06
  - 3 SHA3-256: 17 words, 0x06
  - 4 SHA3-384: 13 words, 0x06
  - 5 SHA3-512: 9 words, 0x06
- in_size_bits[2:0] are ignored (byte-aligned messages only).
- FSM states: IDLE, LOAD, PAD, EMIT.
- IDLE:
  - in_ready=1.
  - A header handshake latches mode, out_size and the remaining counter.
  - Go to LOAD, or to PAD if in_size=0.
- LOAD:
  - in_ready=1.
  - Each accepted word is byte-swapped and shifted into the block at word index wc; wc increments; remaining decrements by W, saturating at 0.
  - Partial last word: valid bytes are the (remaining/8) most-significant bytes of in_data. The first invalid byte becomes the suffix, the remaining bytes become 0, and the pad flag is set.
  - Full last word: the pad flag is not set; move to PAD.
  - After the word that fills wc = rate_words-1, go to EMIT.
- PAD:
  - in_ready=0; one generated word per cycle.
  - The first generated word carries the suffix in byte 0 if the suffix is not yet placed; all other bytes are 0.
  - The final word of the block ORs 0x80 into its highest byte. If the suffix and 0x80 share a byte, the byte is 0x86 or 0x9F.
  - At wc = rate_words-1, go to EMIT with blk_last=1.
- Block boundary with padding pending:
  - If the message ends exactly on a block boundary, EMIT the full block with blk_last=0.
  - Then PAD a whole extra block: suffix in byte 0, 0x80 in the last byte.
- EMIT:
  - blk_valid=1 and in_ready=0; blk_data, blk_last, out_mode and out_size stay stable until blk_ready.
  - On the handshake: wc=0 and blk_data is cleared in the same cycle.
  - Next state is IDLE if blk_last, else LOAD if remaining>0, else PAD.
- Latency: blk_valid rises the cycle after the final word is accepted or generated.
- out_mode and out_size hold from header capture until the next header.
- Reset mid-operation returns to IDLE immediately and clears the partial block; no blk_valid follows.
- in_valid while in_ready=0 is ignored; in_data need not be held.

Optional Feature:
- Macro: KECCAK_LOAD_MODE_CHECK_EN.
- Defined:
  - A header with mode 6 or 7 is discarded and the FSM stays in IDLE.
  - err=1 for exactly one cycle after the header handshake.
  - out_mode and out_size keep their previous values.
- Undefined: err is tied 0, and modes 6 and 7 are treated as mode 0 (SHAKE128).

Test Plan:
- Mode 1, W=64, in_size=0 -> one block after 17 PAD cycles: word0=0x1F, word16=0x8000000000000000, blk_last=1.
- Mode 3, in_size=24, data 0x616263xxxxxxxxxx -> word0=0x0000000006636261, word16 MSB byte=0x80, blk_last=1.
- Mode 5, in_size=576 (exactly 9 words) -> block 1 is data with blk_last=0; block 2 has word0=0x06 and word8=0x8000000000000000, blk_last=1.
- Mode 4, in_size=824 (ends at byte 103 of 104) -> last byte of block 0 = 0x86, single block, blk_last=1.
- blk_ready held low 10 cycles in EMIT -> blk_data stable, in_ready=0; rst pulsed mid-LOAD -> all outputs 0 next edge, no block emitted.
- KECCAK_LOAD_MODE_CHECK_EN defined, header mode=7 -> err pulse of 1 cycle, FSM stays in IDLE; undefined -> processed as SHAKE128, 21-word block.

Source files
------------

// File: rtl/keccak_load_stage.sv
// Sponge load stage: captures a header, byte-swaps message words into a rate-sized block and applies FIPS-202 padding.
// Optional build macro KECCAK_LOAD_MODE_CHECK_EN rejects headers with mode 6/7 and pulses err.
module keccak_load_stage #(
  parameter int W        = 64,
  parameter int RATE_MAX = 1344,
  parameter int SIZE_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [W-1:0]        in_data,
  output logic                blk_valid,
  input  logic                blk_ready,
  output logic [RATE_MAX-1:0] blk_data,
  output logic                blk_last,
  output logic [2:0]          out_mode,
  output logic [SIZE_W-1:0]   out_size,
  output logic                err
);
  localparam int NW   = RATE_MAX / W;
  localparam int WC_W = $clog2(NW);
  localparam int NB   = W / 8;
  localparam int BI_W = $clog2(NB);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PAD  = 2'd2;
  localparam logic [1:0] S_EMIT = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [WC_W-1:0]     wc_q, wc_d;
  logic [SIZE_W-1:0]   rem_q, rem_d;
  logic [RATE_MAX-1:0] blk_q, blk_d;
  logic [2:0]          mode_q, mode_d;
  logic [SIZE_W-1:0]   osize_q, osize_d;
  logic                padded_q, padded_d;  // suffix byte already written
  logic                last_q, last_d;
  logic                err_q, err_d;

  logic [63:0]   hdr;
  logic          hdr_done;
  logic          hdr_beat;
  logic [2:0]    hdr_mode;
  logic          mode_bad;
  logic          hdr_reject;
  logic [W-1:0]  word;
  logic          full;
  logic          at_end;
  logic [7:0]    suffix;
  logic [WC_W-1:0] rate_last;
  logic [BI_W-1:0] nbytes;

  assign hdr_beat = (state_q == S_IDLE) && in_valid;

  if (W == 64) begin : g_hdr64
    assign hdr      = in_data;
    assign hdr_done = 1'b1;
  end else begin : g_hdr32
    // Narrow words carry the header in two beats, high half first.
    logic [31:0] hi_q, hi_d;
    logic        phase_q, phase_d;
    always_comb begin
      hi_d    = hi_q;
      phase_d = phase_q;
      if (hdr_beat) begin
        if (!phase_q) hi_d = in_data;
        phase_d = ~phase_q;
      end
    end
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hi_q    <= '0;
        phase_q <= 1'b0;
      end else begin
        hi_q    <= hi_d;
        phase_q <= phase_d;
      end
    end
    assign hdr      = {hi_q, in_data};
    assign hdr_done = phase_q;
  end

  assign mode_bad = (hdr[63:62] == 2'b11);
`ifdef KECCAK_LOAD_MODE_CHECK_EN
  assign hdr_mode   = hdr[63:61];
  assign hdr_reject = mode_bad;
`else
  assign hdr_mode   = mode_bad ? 3'd0 : hdr[63:61];
  assign hdr_reject = 1'b0;
`endif

  function automatic logic [WC_W-1:0] rate_last_f(input logic [2:0] m);
    int unsigned r;
    case (m)
      3'd1, 3'd3: r = 17;
      3'd2:       r = 18;
      3'd4:       r = 13;
      3'd5:       r = 9;
      default:    r = 21;
    endcase
    return WC_W'(r * (64 / W) - 1);
  endfunction

  assign rate_last = rate_last_f(mode_q);
  assign suffix    = (mode_q < 3'd2) ? 8'h1F : 8'h06;
  assign nbytes    = rem_q[BI_W+2:3];

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    wc_d     = wc_q;
    rem_d    = rem_q;
    blk_d    = blk_q;
    mode_d   = mode_q;
    osize_d  = osize_q;
    padded_d = padded_q;
    last_d   = last_q;
    err_d    = 1'b0;
    word     = '0;
    full     = 1'b0;
    at_end   = (wc_q == rate_last);
    case (state_q)
      S_IDLE: begin
        if (in_valid && hdr_done) begin
          if (hdr_reject) begin
            err_d = 1'b1;
          end else begin
            mode_d   = hdr_mode;
            osize_d  = SIZE_W'({4'b0, hdr[59:32]});
            rem_d    = SIZE_W'({hdr[31:3], 3'b000});
            padded_d = 1'b0;
            last_d   = 1'b0;
            wc_d     = '0;
            state_d  = (hdr[31:3] == '0) ? S_PAD : S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          full = (rem_q >= SIZE_W'(W));
          for (int b = 0; b < NB; b++) begin
            if (full || b < int'(nbytes)) word[8*b +: 8] = in_data[W-1-8*b -: 8];
            else if (b == int'(nbytes))  word[8*b +: 8] = suffix;
          end
          if (!full) padded_d = 1'b1;
          if (!full && at_end) word[W-1 -: 8] = word[W-1 -: 8] | 8'h80;
          rem_d = full ? rem_q - SIZE_W'(W) : '0;
          blk_d[int'(wc_q)*W +: W] = word;
          if (at_end) begin
            state_d = S_EMIT;
            last_d  = !full;
          end else begin
            wc_d = wc_q + 1'b1;
            if (rem_d == '0) state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        if (!padded_q) begin
          word[7:0] = suffix;
          padded_d  = 1'b1;
        end
        if (at_end) begin
          word[W-1 -: 8] = word[W-1 -: 8] | 8'h80;
          state_d = S_EMIT;
          last_d  = 1'b1;
        end else begin
          wc_d = wc_q + 1'b1;
        end
        blk_d[int'(wc_q)*W +: W] = word;
      end
      default: begin
        if (blk_ready) begin
          wc_d    = '0;
          blk_d   = '0;
          last_d  = 1'b0;
          state_d = last_q ? S_IDLE : ((rem_q != '0) ? S_LOAD : S_PAD);
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; the wide block register is
  // reset as well because a reset must discard any partially assembled block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wc_q     <= '0;
      rem_q    <= '0;
      blk_q    <= '0;
      mode_q   <= '0;
      osize_q  <= '0;
      padded_q <= 1'b0;
      last_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wc_q     <= wc_d;
      rem_q    <= rem_d;
      blk_q    <= blk_d;
      mode_q   <= mode_d;
      osize_q  <= osize_d;
      padded_q <= padded_d;
      last_q   <= last_d;
      err_q    <= err_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign blk_valid = (state_q == S_EMIT);
  assign blk_data  = blk_q;
  assign blk_last  = last_q;
  assign out_mode  = mode_q;
  assign out_size  = osize_q;
  assign err       = err_q;

  logic unused_hdr;
  assign unused_hdr = ^{hdr[60], hdr[2:0]};
endmodule

// File: tb/tb_keccak_load_stage.sv
// Directed bench for keccak_load_stage (W=64): padding, block boundaries, back-pressure, reset and mode checks.
module tb_keccak_load_stage;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_data = '0;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic [1343:0] blk_data;
  logic          blk_last;
  logic [2:0]    out_mode;
  logic [31:0]   out_size;
  logic          err;

  int tests_run    = 0;
  int tests_failed = 0;

  keccak_load_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
    .blk_last(blk_last), .out_mode(out_mode), .out_size(out_size), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] bswap(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[63-8*i -: 8];
    return r;
  endfunction

  function automatic int first_diff(input logic [1343:0] a, input logic [1343:0] b);
    for (int i = 0; i < 21; i++) if (a[i*64 +: 64] !== b[i*64 +: 64]) return i;
    return 0;
  endfunction

  task automatic send(input logic [63:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n == 50) begin
      tests_run++; tests_failed++;
      $display("FAIL send: in_ready stuck low for %0d cycles", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_blk(input int limit, output int n);
    n = 0;
    while (blk_valid !== 1'b1 && n < limit) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic take_block();
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if ({blk_valid, blk_last, err, out_mode, out_size} !== '0 || blk_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got v=%b l=%b e=%b m=%0d s=%0d data_nz=%b expected all 0",
               blk_valid, blk_last, err, out_mode, out_size, |blk_data);
    end
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_idle_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_mode1_empty();
    logic [1343:0] exp = '0;
    int n, k;
    send(64'h2000_0100_0000_0000);
    wait_blk(40, n);
    tests_run++;
    if (n !== 17) begin
      tests_failed++; $display("FAIL mode1_latency: got %0d cycles expected 17", n);
    end
    exp[63:0]      = 64'h1F;
    exp[16*64 +: 64] = 64'h8000_0000_0000_0000;
    tests_run++;
    if (blk_data !== exp) begin
      tests_failed++; k = first_diff(blk_data, exp);
      $display("FAIL mode1_block: word %0d got %h expected %h", k, blk_data[k*64 +: 64], exp[k*64 +: 64]);
    end
    tests_run++;
    if (blk_last !== 1'b1 || out_mode !== 3'd1 || out_size !== 32'd256) begin
      tests_failed++;
      $display("FAIL mode1_fields: got last=%b mode=%0d size=%0d expected 1/1/256", blk_last, out_mode, out_size);
    end
    take_block();
    tests_run++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b1 || blk_data !== '0) begin
      tests_failed++;
      $display("FAIL mode1_after: got valid=%b ready=%b data_nz=%b expected 0/1/0", blk_valid, in_ready, |blk_data);
    end
  endtask

  task automatic test_mode3_abc();
    logic [1343:0] exp = '0;
    int n, k;
    send(64'h6000_0020_0000_0018);
    send(64'h6162_63DE_ADBE_EFAA);
    wait_blk(40, n);
    tests_run++;
    if (n !== 16) begin
      tests_failed++; $display("FAIL mode3_latency: got %0d cycles expected 16", n);
    end
    exp[63:0]        = 64'h0000_0000_0663_6261;
    exp[16*64 +: 64] = 64'h8000_0000_0000_0000;
    tests_run++;
    if (blk_data !== exp) begin
      tests_failed++; k = first_diff(blk_data, exp);
      $display("FAIL mode3_block: word %0d got %h expected %h", k, blk_data[k*64 +: 64], exp[k*64 +: 64]);
    end
    tests_run++;
    if (blk_last !== 1'b1 || out_mode !== 3'd3 || out_size !== 32'd32) begin
      tests_failed++;
      $display("FAIL mode3_fields: got last=%b mode=%0d size=%0d expected 1/3/32", blk_last, out_mode, out_size);
    end
    take_block();
  endtask

  task automatic test_mode5_boundary();
    logic [1343:0] exp = '0;
    logic [63:0] d;
    int n, k;
    send(64'hA000_0200_0000_0240);
    for (int i = 0; i < 9; i++) begin
      d = 64'h0102_0304_0506_0708 + 64'h1111_1111_1111_1111 * i;
      exp[i*64 +: 64] = bswap(d);
      send(d);
    end
    tests_run++;
    if (blk_valid !== 1'b1 || blk_last !== 1'b0) begin
      tests_failed++; $display("FAIL mode5_blk1_flags: got valid=%b last=%b expected 1/0", blk_valid, blk_last);
    end
    tests_run++;
    if (blk_data !== exp) begin
      tests_failed++; k = first_diff(blk_data, exp);
      $display("FAIL mode5_blk1_data: word %0d got %h expected %h", k, blk_data[k*64 +: 64], exp[k*64 +: 64]);
    end
    take_block();
    wait_blk(40, n);
    tests_run++;
    if (n !== 9) begin
      tests_failed++; $display("FAIL mode5_pad_latency: got %0d cycles expected 9", n);
    end
    exp = '0;
    exp[63:0]       = 64'h06;
    exp[8*64 +: 64] = 64'h8000_0000_0000_0000;
    tests_run++;
    if (blk_data !== exp || blk_last !== 1'b1) begin
      tests_failed++; k = first_diff(blk_data, exp);
      $display("FAIL mode5_blk2: last=%b word %0d got %h expected %h", blk_last, k, blk_data[k*64 +: 64], exp[k*64 +: 64]);
    end
    take_block();
  endtask

  task automatic test_mode4_shared_byte();
    logic [1343:0] exp = '0;
    logic [63:0] d;
    int n, k;
    send(64'h8000_0180_0000_0338);
    for (int i = 0; i < 12; i++) begin
      d = 64'hA0A1_A2A3_A4A5_A6A7 ^ (64'h0101_0101_0101_0101 * i);
      exp[i*64 +: 64] = bswap(d);
      send(d);
    end
    send(64'h1122_3344_5566_7788);
    exp[12*64 +: 64] = 64'h8677_6655_4433_2211;
    wait_blk(5, n);
    tests_run++;
    if (n !== 0) begin
      tests_failed++; $display("FAIL mode4_latency: got %0d cycles expected 0", n);
    end
    tests_run++;
    if (blk_data !== exp || blk_last !== 1'b1) begin
      tests_failed++; k = first_diff(blk_data, exp);
      $display("FAIL mode4_block: last=%b word %0d got %h expected %h", blk_last, k, blk_data[k*64 +: 64], exp[k*64 +: 64]);
    end
    take_block();
    wait_blk(30, n);
    tests_run++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL mode4_single_block: got valid=%b ready=%b expected 0/1", blk_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [1343:0] exp = '0;
    int n, k;
    send(64'h4000_00E0_0000_0008);
    send(64'hAB00_0000_0000_0000);
    wait_blk(40, n);
    exp[63:0]         = 64'h06AB;
    exp[17*64 +: 64]  = 64'h8000_0000_0000_0000;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_data  = {$urandom, $urandom};
      tests_run++;
      if (blk_valid !== 1'b1 || in_ready !== 1'b0 || blk_last !== 1'b1 || blk_data !== exp) begin
        tests_failed++; k = first_diff(blk_data, exp);
        $display("FAIL backpressure_hold c%0d: valid=%b ready=%b last=%b word %0d got %h expected %h",
                 c, blk_valid, in_ready, blk_last, k, blk_data[k*64 +: 64], exp[k*64 +: 64]);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    take_block();
    tests_run++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b0 || out_mode !== 3'd2 || out_size !== 32'd224) begin
      tests_failed++;
      $display("FAIL backpressure_after: ready=%b valid=%b mode=%0d size=%0d expected 1/0/2/224",
               in_ready, blk_valid, out_mode, out_size);
    end
  endtask

  task automatic test_mode7();
    int n;
`ifdef KECCAK_LOAD_MODE_CHECK_EN
    send(64'hE000_0000_0000_0040);
    tests_run++;
    if (err !== 1'b1) begin
      tests_failed++; $display("FAIL mode7_err_pulse: got %b expected 1", err);
    end
    @(posedge clk); #1;
    tests_run++;
    if (err !== 1'b0 || in_ready !== 1'b1 || out_mode !== 3'd2 || out_size !== 32'd224) begin
      tests_failed++;
      $display("FAIL mode7_discard: err=%b ready=%b mode=%0d size=%0d expected 0/1/2/224", err, in_ready, out_mode, out_size);
    end
    wait_blk(25, n);
    tests_run++;
    if (blk_valid !== 1'b0) begin
      tests_failed++; $display("FAIL mode7_no_block: got valid=%b expected 0", blk_valid);
    end
`else
    logic [1343:0] exp = '0;
    int k;
    send(64'hE000_0000_0000_0040);
    tests_run++;
    if (err !== 1'b0) begin
      tests_failed++; $display("FAIL mode7_err_tied: got %b expected 0", err);
    end
    send(64'h0102_0304_0506_0708);
    wait_blk(40, n);
    tests_run++;
    if (n !== 20) begin
      tests_failed++; $display("FAIL mode7_latency: got %0d cycles expected 20", n);
    end
    exp[63:0]        = 64'h0807_0605_0403_0201;
    exp[127:64]      = 64'h1F;
    exp[20*64 +: 64] = 64'h8000_0000_0000_0000;
    tests_run++;
    if (blk_data !== exp || blk_last !== 1'b1) begin
      tests_failed++; k = first_diff(blk_data, exp);
      $display("FAIL mode7_shake128_block: last=%b word %0d got %h expected %h", blk_last, k, blk_data[k*64 +: 64], exp[k*64 +: 64]);
    end
    take_block();
`endif
  endtask

  task automatic test_reset_mid_load();
    int n;
    send(64'h6000_0100_0000_0400);
    for (int i = 0; i < 3; i++) send(64'hFEED_0000_0000_0000 + 64'(i));
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({blk_valid, blk_last, err, out_mode, out_size} !== '0 || blk_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_load: v=%b l=%b e=%b m=%0d s=%0d data_nz=%b expected all 0",
               blk_valid, blk_last, err, out_mode, out_size, |blk_data);
    end
    rst = 1'b0;
    wait_blk(30, n);
    tests_run++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL reset_no_block: got valid=%b ready=%b expected 0/1", blk_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_mode1_empty();
    test_mode3_abc();
    test_mode5_boundary();
    test_mode4_shared_byte();
    test_backpressure();
    test_mode7();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
